qpp_addr_gen: RTL and testbench
===============================

# qpp_addr_gen

Sequential QPP interleaver address generator for the turbo interleaver: given a block size K and coefficients f1, f2 (typically from the f1/f2 parameter table), streams π(i) = (f1·i + f2·i²) mod K for i = 0..K-1, one address per cycle. It uses a multiplier-free recursion and a valid/ready output with backpressure. It sits between the parameter table and the interleaver memory address port, and supports any runtime K up to 2^KW-1.

## Interface
- KW, 13, width of K, f1, f2, addresses and indices (13 covers K ≤ 6144)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  start request; accepted only in IDLE
- k_i  in  KW  block size K, sampled on accepted start
- f1_i  in  KW  coefficient f1, sampled on accepted start; f1 < K required
- f2_i  in  KW  coefficient f2, sampled on accepted start; f2 < K required
- busy_o  out  1  high from accepted start until done
- addr_o  out  KW  π(i)
- idx_o  out  KW  i
- valid_o  out  1  addr_o/idx_o valid
- ready_i  in  1  downstream accepts beat when valid_o & ready_i
- last_o  out  1  marks beat i = K-1
- done_o  out  1  one-cycle pulse on completion
- err_o  out  1  parameter error; present only with QPP_CHECK_EN

## Operation
- Recursion: π(0)=0, g(0)=(f1+f2) mod K, d=(2·f2) mod K; π(i+1)=(π(i)+g(i)) mod K; g(i+1)=(g(i)+d) mod K.
- Every modular add takes operands < K: form a (KW+1)-bit sum, subtract K if sum ≥ K. There are no multipliers or dividers.
- States:
  - IDLE → SETUP on start_i. Registers k_i, f1_i, f2_i. busy_o=1.
  - SETUP (1 cycle) computes g(0) and d, loads π=0, i=0 → RUN.
  - RUN holds valid_o=1. On each handshake, advance i, π and g. On the handshake with i=K-1 → IDLE, done_o=1 for one cycle, busy_o=0.
- Backpressure: while valid_o & !ready_i, addr_o, idx_o and last_o are held stable and the recursion is frozen.
- start_i outside IDLE is ignored. start_i in the same cycle as done_o is ignored; it is accepted from the next cycle.
- K=1: a single beat, addr 0, last_o=1.
- K=0 without the macro: SETUP → IDLE directly, no beats, done_o pulses.
- Reset, including mid-RUN: state → IDLE. All outputs 0: busy_o, valid_o, last_o, done_o, err_o, addr_o, idx_o. Any in-flight block is abandoned without a done_o pulse.

## Timing
- start_i accepted in cycle T → SETUP at T+1 → first valid_o at T+2.
- With ready_i held high, beat i appears at T+2+i. done_o is at T+2+K, in the cycle after the last handshake.
- Throughput: 1 address/cycle. All outputs are registered. Critical path is one (KW+1)-bit add plus a compare/subtract.

## Configuration
- QPP_CHECK_EN defined:
  - SETUP also checks K < 2, f1 even, f2 odd, f1 ≥ K and f2 ≥ K.
  - Any violation → ERR state. err_o=1, no beats are produced, busy_o stays 1.
  - ERR exits to IDLE only on rst. done_o never pulses for an erroneous block.
- Not defined: no checks, no err_o port, no ERR state. Behaviour for illegal parameters is limited to the K=0 rule above.

## Structure
- Shared package qpp_pkg holds:
  - the state enum (IDLE, SETUP, RUN, ERR)
  - default KW = 13
  - LTE K limits (K_MIN = 40, K_MAX = 6144) for bench use
- One sub-module, qpp_mod_add: combinational (a+b) mod K for a, b < K. It is instantiated three times: π update, g update, setup.

## Test plan
- K=40, f1=3, f2=10, ready_i=1 → addr 0, 13, 6, 19, … ; beat 39 = 7 with last_o=1; done_o at T+42; the 40 addresses are a permutation of 0..39.
- K=6144, f1=263, f2=480 → addr 0, 743, 2446, …; all 6144 beats match a reference model and form a permutation; last_o only on idx 6143.
- K=40, f1=3, f2=10 with random ready_i → outputs are stable while stalled; same sequence as the unstalled run.
- start_i pulsed during RUN, and again in the done_o cycle → ignored; the next start one cycle later begins a new block correctly.
- rst asserted at beat 17 of K=40 → all outputs 0 the next cycle, no done_o; a fresh start then yields addr 0, 13, ….
- K=1 → one beat, addr 0, last_o=1. With QPP_CHECK_EN: f1=4, K=40 → err_o=1, no valid_o until rst.

Source files
------------

// File: rtl/qpp_pkg.sv
// Shared definitions for the QPP interleaver address generator.
// The ERR state exists only when QPP_CHECK_EN is defined.
package qpp_pkg;

    localparam int unsigned QPP_KW = 13;
    localparam int unsigned K_MIN  = 40;
    localparam int unsigned K_MAX  = 6144;

`ifdef QPP_CHECK_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_ERR
    } qpp_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN
    } qpp_state_e;
`endif

endpackage

// File: rtl/qpp_mod_add.sv
// Combinational (a + b) mod k for operands already reduced below k.
module qpp_mod_add #(
    parameter int unsigned W = 13
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] k,
    output logic [W-1:0] y
);

    logic [W:0] sum;
    logic [W:0] kx;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        kx  = {1'b0, k};
        y   = (sum >= kx) ? W'(sum - kx) : W'(sum);
    end

endmodule

// File: rtl/qpp_addr_gen.sv
// Sequential QPP interleaver address generator: pi(i) = (f1*i + f2*i^2) mod K
// via an add-only recursion. QPP_CHECK_EN adds parameter checks, err_o and ERR.
module qpp_addr_gen
    import qpp_pkg::*;
#(
    parameter int unsigned KW = QPP_KW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [KW-1:0] k_i,
    input  logic [KW-1:0] f1_i,
    input  logic [KW-1:0] f2_i,
    output logic          busy_o,
    output logic [KW-1:0] addr_o,
    output logic [KW-1:0] idx_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          last_o,
    output logic          done_o
`ifdef QPP_CHECK_EN
    ,
    output logic          err_o
`endif
);

    qpp_state_e state_q, state_d;

    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] f1_q, f1_d;
    logic [KW-1:0] f2_q, f2_d;
    logic [KW-1:0] g_q, g_d;
    logic [KW-1:0] d_q, d_d;
    logic [KW-1:0] pi_q, pi_d;
    logic [KW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
`ifdef QPP_CHECK_EN
    logic          err_q, err_d;
    logic          param_bad;
`endif

    logic [KW-1:0] pi_nxt;
    logic [KW-1:0] g_nxt;
    logic [KW-1:0] g0;
    logic [KW-1:0] g_a;
    logic [KW-1:0] g_b;
    logic [KW-1:0] idx_inc;
    logic [KW-1:0] k_m1;

    // The g-update adder doubles as the d = 2*f2 mod K adder during SETUP.
    assign g_a     = (state_q == ST_SETUP) ? f2_q : g_q;
    assign g_b     = (state_q == ST_SETUP) ? f2_q : d_q;
    assign idx_inc = idx_q + KW'(1);
    assign k_m1    = k_q - KW'(1);

    qpp_mod_add #(.W(KW)) u_pi_add (
        .a (pi_q),
        .b (g_q),
        .k (k_q),
        .y (pi_nxt)
    );

    qpp_mod_add #(.W(KW)) u_g_add (
        .a (g_a),
        .b (g_b),
        .k (k_q),
        .y (g_nxt)
    );

    qpp_mod_add #(.W(KW)) u_setup_add (
        .a (f1_q),
        .b (f2_q),
        .k (k_q),
        .y (g0)
    );

`ifdef QPP_CHECK_EN
    assign param_bad = (k_q < KW'(2)) || !f1_q[0] || f2_q[0] ||
                       (f1_q >= k_q) || (f2_q >= k_q);
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        f1_d    = f1_q;
        f2_d    = f2_q;
        g_d     = g_q;
        d_d     = d_q;
        pi_d    = pi_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
`ifdef QPP_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A start coinciding with the done pulse is deliberately dropped.
                if (start_i && !done_q) begin
                    state_d = ST_SETUP;
                    k_d     = k_i;
                    f1_d    = f1_i;
                    f2_d    = f2_i;
                    busy_d  = 1'b1;
                end
            end
            ST_SETUP: begin
`ifdef QPP_CHECK_EN
                if (param_bad) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else
`endif
                if (k_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    g_d     = g0;
                    d_d     = g_nxt;
                    pi_d    = '0;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    last_d  = (k_q == KW'(1));
                end
            end
            ST_RUN: begin
                if (valid_q && ready_i) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        pi_d   = pi_nxt;
                        g_d    = g_nxt;
                        idx_d  = idx_inc;
                        last_d = (idx_inc == k_m1);
                    end
                end
            end
`ifdef QPP_CHECK_EN
            ST_ERR: begin
                state_d = ST_ERR;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            f1_q    <= '0;
            f2_q    <= '0;
            g_q     <= '0;
            d_q     <= '0;
            pi_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef QPP_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            g_q     <= g_d;
            d_q     <= d_d;
            pi_q    <= pi_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef QPP_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign busy_o  = busy_q;
    assign addr_o  = pi_q;
    assign idx_o   = idx_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign done_o  = done_q;
`ifdef QPP_CHECK_EN
    assign err_o   = err_q;
`endif

endmodule

// File: tb/tb_qpp_addr_gen.sv
// Scoreboard bench for qpp_addr_gen: expected beats come from the closed-form
// QPP polynomial, a monitor pops and compares on every handshake.
module tb_qpp_addr_gen;
    import qpp_pkg::*;

    localparam int unsigned KW = QPP_KW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [KW-1:0] k_i, f1_i, f2_i;
    logic          busy_o;
    logic [KW-1:0] addr_o, idx_o;
    logic          valid_o;
    logic          ready_i;
    logic          last_o;
    logic          done_o;
`ifdef QPP_CHECK_EN
    logic          err_o;
`endif

    qpp_addr_gen #(.KW(KW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .k_i     (k_i),
        .f1_i    (f1_i),
        .f2_i    (f2_i),
        .busy_o  (busy_o),
        .addr_o  (addr_o),
        .idx_o   (idx_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .last_o  (last_o),
        .done_o  (done_o)
`ifdef QPP_CHECK_EN
        ,
        .err_o   (err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int idx;
        bit last;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    n_obs    = 0;
    int    done_cnt = 0;
    int    obs_addr [0:K_MAX-1];
    int    obs_cyc  [0:K_MAX-1];
    bit            stall_prev = 1'b0;
    logic [KW-1:0] addr_prev, idx_prev;
    logic          last_prev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int qpp(input int k, input int f1, input int f2, input int i);
        longint v;
        v = longint'(f1) * i + longint'(f2) * i * i;
        return int'(v % k);
    endfunction

    // Monitor: compares each handshake against the scoreboard and checks stall stability.
    always @(negedge clk) begin
        if (stall_prev && !rst) begin
            chk("stall_valid", valid_o, 1);
            chk("stall_addr", addr_o, addr_prev);
            chk("stall_idx", idx_o, idx_prev);
            chk("stall_last", last_o, last_prev);
        end
        if (done_o) done_cnt++;
        if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got idx %0d addr %0d, expected no beat", idx_o, addr_o);
            end else begin
                mon_e = sb.pop_front();
                chk("beat_addr", addr_o, mon_e.addr);
                chk("beat_idx", idx_o, mon_e.idx);
                chk("beat_last", last_o, mon_e.last);
                if (n_obs < K_MAX) begin
                    obs_addr[n_obs] = int'(addr_o);
                    obs_cyc[n_obs]  = cyc;
                end
                n_obs++;
            end
        end
        stall_prev = valid_o && !ready_i && !rst;
        addr_prev  = addr_o;
        idx_prev   = idx_o;
        last_prev  = last_o;
    end

    task automatic push_block(input int k, input int f1, input int f2, input int n);
        for (int i = 0; i < n; i++)
            sb.push_back('{addr: qpp(k, f1, f2, i), idx: i, last: (i == k - 1)});
    endtask

    // Start is high for exactly one cycle; t is the cycle it is presented in.
    task automatic pulse_start(input int k, input int f1, input int f2, output int t);
        @(posedge clk); #1;
        k_i = KW'(k); f1_i = KW'(f1); f2_i = KW'(f2);
        start_i = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int bound, input bit rand_rdy, output int t);
        bit ok = 1'b0;
        t = -1;
        for (int n = 0; n < bound; n++) begin
            @(posedge clk); #1;
            if (done_o) begin
                ok = 1'b1;
                t = cyc;
                break;
            end
            if (rand_rdy) ready_i = ($urandom_range(0, 2) != 0);
        end
        ready_i = 1'b1;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done_o, expected one within %0d cycles", bound);
        end
    endtask

    task automatic end_block(input int k, input int t_start, input int t_done, input bit timing);
        bit seen [0:K_MAX-1];
        int distinct = 0;
        for (int i = 0; i < K_MAX; i++) seen[i] = 1'b0;
        chk("queue_drained", sb.size(), 0);
        chk("beat_count", n_obs, k);
        chk("done_busy_low", busy_o, 0);
        chk("done_valid_low", valid_o, 0);
        for (int i = 0; i < k && i < n_obs && i < K_MAX; i++) begin
            if (obs_addr[i] >= 0 && obs_addr[i] < K_MAX && !seen[obs_addr[i]]) begin
                seen[obs_addr[i]] = 1'b1;
                distinct++;
            end
        end
        chk("permutation", distinct, k);
        if (timing) begin
            chk("done_cycle", t_done, t_start + 2 + k);
            if (k > 0) chk("first_beat_cycle", obs_cyc[0], t_start + 2);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int t, td, d0;
        rst = 1'b1; start_i = 1'b0; ready_i = 1'b1;
        k_i = '0; f1_i = '0; f2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_idx", idx_o, 0);
        rst = 1'b0;

        // K=40, f1=3, f2=10, no backpressure
        n_obs = 0;
        push_block(40, 3, 10, 40);
        pulse_start(40, 3, 10, t);
        chk("setup_busy", busy_o, 1);
        chk("setup_valid", valid_o, 0);
        wait_done(200, 1'b0, td);
        end_block(40, t, td, 1'b1);
        chk("k40_addr1", obs_addr[1], 13);
        chk("k40_addr2", obs_addr[2], 6);
        chk("k40_addr3", obs_addr[3], 19);
        chk("k40_addr39", obs_addr[39], 7);
        chk("k40_last_cycle", obs_cyc[39], t + 41);

        // Largest LTE block
        n_obs = 0;
        push_block(K_MAX, 263, 480, K_MAX);
        pulse_start(K_MAX, 263, 480, t);
        wait_done(K_MAX + 100, 1'b0, td);
        end_block(K_MAX, t, td, 1'b1);
        chk("k6144_addr1", obs_addr[1], 743);
        chk("k6144_addr2", obs_addr[2], 2446);

        // Random backpressure
        n_obs = 0;
        push_block(40, 3, 10, 40);
        pulse_start(40, 3, 10, t);
        wait_done(1000, 1'b1, td);
        end_block(40, t, td, 1'b0);

        // Start during RUN and in the done cycle must be ignored
        n_obs = 0;
        push_block(40, 3, 10, 40);
        pulse_start(40, 3, 10, t);
        repeat (5) begin @(posedge clk); #1; end
        k_i = KW'(20); f1_i = KW'(1); f2_i = KW'(2);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(200, 1'b0, td);
        end_block(40, t, td, 1'b1);
        k_i = KW'(12); f1_i = KW'(1); f2_i = KW'(6);
        start_i = 1'b1;
        @(posedge clk); #1;
        n_obs = 0;
        push_block(40, 3, 10, 40);
        k_i = KW'(40); f1_i = KW'(3); f2_i = KW'(10);
        t = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("restart_busy", busy_o, 1);
        wait_done(200, 1'b0, td);
        end_block(40, t, td, 1'b1);

        // Reset at beat 17 abandons the block
        n_obs = 0;
        push_block(40, 3, 10, 18);
        pulse_start(40, 3, 10, t);
        for (int n = 0; n < 100; n++) begin
            if (valid_o && idx_o == KW'(17)) break;
            @(posedge clk); #1;
        end
        chk("pre_rst_idx", idx_o, 17);
        rst = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_last", last_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_addr", addr_o, 0);
        chk("midrst_idx", idx_o, 0);
        rst = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("midrst_no_done", done_cnt, d0);
        chk("midrst_queue", sb.size(), 0);
        n_obs = 0;
        push_block(40, 3, 10, 40);
        pulse_start(40, 3, 10, t);
        wait_done(200, 1'b0, td);
        end_block(40, t, td, 1'b1);
        chk("postrst_addr1", obs_addr[1], 13);

        // K=1: single beat
        n_obs = 0;
        push_block(1, 0, 0, 1);
        pulse_start(1, 0, 0, t);
        wait_done(20, 1'b0, td);
        end_block(1, t, td, 1'b1);
        chk("k1_addr", obs_addr[0], 0);

`ifndef QPP_CHECK_EN
        // K=0: no beats, done straight from SETUP
        n_obs = 0;
        pulse_start(0, 0, 0, t);
        wait_done(20, 1'b0, td);
        chk("k0_beats", n_obs, 0);
        chk("k0_done_cycle", td, t + 2);
`else
        n_obs = 0;
        pulse_start(40, 4, 10, t);
        repeat (10) begin @(posedge clk); #1; end
        chk("err_flag", err_o, 1);
        chk("err_busy", busy_o, 1);
        chk("err_beats", n_obs, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("err_cleared", err_o, 0);
        rst = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
